// File: rtl/pipe_pkg.sv
// Shared pipe-gap types and constants: FSM states, default
// LFSR taps/seeds per width, screen y limits shared with the renderer.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    CLAMP
  } gap_state_e;

  localparam logic [7:0] TAPS8  = 8'h1C;
  localparam logic [7:0] SEED8  = 8'hCD;
  localparam logic [8:0] TAPS9  = 9'h070;
  localparam logic [8:0] SEED9  = 9'd205;
  localparam logic [9:0] TAPS10 = 10'h008;
  localparam logic [9:0] SEED10 = 10'd205;

  localparam int unsigned SCREEN_MIN_Y = 80;
  localparam int unsigned SCREEN_MAX_Y = 335;

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR: rotate-left with TAPS folded in when MSB is set.
// Ports: clk, rst_n, step, load, load_val in; q out (current state).
module lfsr_galois
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH = 9,
  parameter logic [WIDTH-1:0] TAPS  = TAPS9,
  parameter logic [WIDTH-1:0] SEED  = SEED9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] nxt;

  assign nxt = {q_q[WIDTH-2:0], q_q[WIDTH-1]}
             ^ (q_q[WIDTH-1] ? TAPS : '0);

  // Zero is a dead state: a zero load falls back to SEED,
  // and a zero state is pulled back to SEED on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else if (load) begin
      q_q <= (load_val == '0) ? SEED : load_val;
    end else if (q_q == '0) begin
      q_q <= SEED;
    end else if (step) begin
      q_q <= nxt;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_gap_gen.sv
// Pipe gap generator: LFSR value mapped into [MIN_Y, MAX_Y], optional
// step clamp. Ports: req/ready/gap_y/gap_valid handshake, stir, seed load.
module pipe_gap_gen
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 9,
  parameter logic [WIDTH-1:0] TAPS      = TAPS9,
  parameter logic [WIDTH-1:0] SEED      = SEED9,
  parameter int unsigned      MIN_Y     = SCREEN_MIN_Y,
  parameter int unsigned      MAX_Y     = SCREEN_MAX_Y,
  parameter int unsigned      MAX_DELTA = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  output logic             ready,
  output logic [WIDTH-1:0] gap_y,
  output logic             gap_valid,
  input  logic             stir,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_val
);

  localparam int unsigned EW   = WIDTH + 1;
  localparam int unsigned SPAN = MAX_Y - MIN_Y + 1;

  localparam logic [EW-1:0]    SPAN_E = EW'(SPAN);
  localparam logic [WIDTH-1:0] SPAN_W = SPAN_E[WIDTH-1:0];
  localparam logic [EW-1:0]    MIN_E  = EW'(MIN_Y);
  localparam logic [EW-1:0]    D_E    = EW'(MAX_DELTA);
  localparam logic [WIDTH-1:0] D_W    = WIDTH'(MAX_DELTA);
  localparam logic [WIDTH-1:0] MID    = WIDTH'((MIN_Y + MAX_Y) / 2);

  gap_state_e       state_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] gap_q;
  logic [WIDTH-1:0] prev_q;
  logic             valid_q;

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_nxt;
  logic             idle;
  logic             step;

  logic [EW-1:0]    raw_e;
  logic [EW-1:0]    up_e;
  logic [EW-1:0]    hi_e;
  logic [EW-1:0]    prev_e;
  logic [WIDTH-1:0] clamp_d;

  assign idle = (state_q == IDLE);
  // req and stir together advance once; seed_load masks both.
  assign step = idle & ~seed_load & (req | stir);

  assign lfsr_nxt = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1]}
                  ^ (lfsr_q[WIDTH-1] ? TAPS : '0);

  lfsr_galois #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .load     (seed_load),
    .load_val (seed_val),
    .q        (lfsr_q)
  );

  // One extra bit so prev+delta and raw+delta never wrap.
  assign raw_e  = MIN_E + {1'b0, r_q};
  assign up_e   = raw_e + D_E;
  assign prev_e = {1'b0, prev_q};
  assign hi_e   = prev_e + D_E;

  always_comb begin
    clamp_d = raw_e[WIDTH-1:0];
    if (MAX_DELTA != 0) begin
      if (raw_e > hi_e) begin
        clamp_d = prev_q + D_W;
      end else if (up_e < prev_e) begin
        clamp_d = prev_q - D_W;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      gap_q   <= MID;
      prev_q  <= MID;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (seed_load) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (req) begin
              r_q     <= lfsr_nxt;
              state_q <= REDUCE;
            end
          end
          REDUCE: begin
            if ({1'b0, r_q} >= SPAN_E) begin
              r_q <= r_q - SPAN_W;
            end else begin
              state_q <= CLAMP;
            end
          end
          CLAMP: begin
            gap_q   <= clamp_d;
            prev_q  <= clamp_d;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ready     = idle;
  assign gap_y     = gap_q;
  assign gap_valid = valid_q;

endmodule

// File: tb/tb_pipe_gap_gen.sv
// Scoreboard bench for pipe_gap_gen: two instances, clamp off
// (dut0) and MAX_DELTA=40 (dut1), directed stimulus.
module tb_pipe_gap_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0;
  logic       req1;
  logic       stir;
  logic       seed_load;
  logic [8:0] seed_val;
  logic       rdy0;
  logic       rdy1;
  logic       gv0;
  logic       gv1;
  logic [8:0] gy0;
  logic [8:0] gy1;

  always #5 clk = ~clk;

  pipe_gap_gen #(.MAX_DELTA(0)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req0),
    .ready     (rdy0),
    .gap_y     (gy0),
    .gap_valid (gv0),
    .stir      (stir),
    .seed_load (seed_load),
    .seed_val  (seed_val)
  );

  pipe_gap_gen #(.MAX_DELTA(40)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req1),
    .ready     (rdy1),
    .gap_y     (gy1),
    .gap_valid (gv1),
    .stir      (stir),
    .seed_load (seed_load),
    .seed_val  (seed_val)
  );

  typedef struct {
    int y;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  // Monitor: pop and compare on every gap_valid.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (gv0) begin
        if (q0.size() == 0) begin
          chk("dut0 unexpected valid", 1, 0);
        end else begin
          e0 = q0.pop_front();
          chk("dut0 gap_y", int'(gy0), e0.y);
          chk("dut0 latency", cyc, e0.cyc);
        end
      end
      if (gv1) begin
        if (q1.size() == 0) begin
          chk("dut1 unexpected valid", 1, 0);
        end else begin
          e1 = q1.pop_front();
          chk("dut1 gap_y", int'(gy1), e1.y);
          chk("dut1 latency", cyc, e1.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; req is sampled on the next edge.
  task automatic issue(input bit d0, input bit d1,
                       input int y0, input int y1,
                       input int k, input bit push);
    if (push && d0) q0.push_back(exp_t'{y: y0, cyc: cyc + 3 + k});
    if (push && d1) q1.push_back(exp_t'{y: y1, cyc: cyc + 3 + k});
    req0 = d0;
    req1 = d1;
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic wait_done(input string n);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (q0.size() == 0 && q1.size() == 0 && rdy0 && !gv0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({n, " timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [8:0] stp(input logic [8:0] s);
    return {s[7:0], s[8]} ^ (s[8] ? 9'h070 : 9'h000);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] m;
    int c;
    int zero_hits;
    int k;

    rst_n     = 1'b0;
    req0      = 1'b0;
    req1      = 1'b0;
    stir      = 1'b0;
    seed_load = 1'b0;
    seed_val  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("reset ready", int'(rdy0), 1);
    chk("reset gap_y", int'(gy0), 207);
    chk("reset valid", int'(gv0), 0);
    chk("reset gap_y clamp", int'(gy1), 207);

    // 205 -> 410 (234), 410 -> 325 (149, clamped 194 on dut1)
    issue(1, 1, 234, 234, 1, 1);
    wait_done("first req");
    issue(1, 1, 149, 194, 1, 1);
    wait_done("second req");

    // req held high: accepted at c+1 and c+5 only
    do_reset();
    c = cyc;
    q0.push_back(exp_t'{y: 234, cyc: c + 4});
    q0.push_back(exp_t'{y: 149, cyc: c + 8});
    req0 = 1'b1;
    tick();
    chk("held req ready low", int'(rdy0), 0);
    repeat (5) tick();
    req0 = 1'b0;
    wait_done("held req");

    // req with stir in the same cycle: one advance only
    do_reset();
    stir = 1'b1;
    issue(1, 0, 234, 0, 1, 1);
    stir = 1'b0;
    wait_done("req+stir");
    issue(1, 0, 149, 0, 1, 1);
    wait_done("after req+stir");

    // one stir then req samples the second step
    do_reset();
    stir = 1'b1;
    tick();
    stir = 1'b0;
    issue(1, 0, 149, 0, 1, 1);
    wait_done("stir then req");

    // zero seed_load aborts a request in REDUCE
    do_reset();
    issue(1, 0, 0, 0, 0, 0);
    seed_load = 1'b1;
    seed_val  = 9'd0;
    tick();
    seed_load = 1'b0;
    chk("abort ready", int'(rdy0), 1);
    chk("abort gap_y", int'(gy0), 207);
    repeat (6) tick();
    chk("zero seed lfsr", int'(u_dut0.u_lfsr.q_q), 205);
    issue(1, 0, 234, 0, 1, 1);
    wait_done("after zero seed");
    seed_load = 1'b1;
    seed_val  = 9'h1FF;
    tick();
    seed_load = 1'b0;
    issue(1, 0, 223, 0, 1, 1);
    wait_done("seed 1FF");

    // async reset mid-REDUCE
    issue(1, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst ready", int'(rdy0), 1);
    chk("async rst gap_y", int'(gy0), 207);
    chk("async rst valid", int'(gv0), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 511 stir steps, then a request
    m = 9'd205;
    zero_hits = 0;
    stir = 1'b1;
    repeat (511) begin
      tick();
      m = stp(m);
      if (u_dut0.u_lfsr.q_q == 9'd0) zero_hits++;
    end
    stir = 1'b0;
    chk("lfsr after 511 stirs", int'(u_dut0.u_lfsr.q_q), int'(m));
    chk("lfsr zero hits", zero_hits, 0);
    m = stp(m);
    k = (m >= 9'd256) ? 1 : 0;
    issue(1, 0, 80 + int'(m) - 256 * k, 0, k, 1);
    wait_done("after 511 stirs");

    chk("dut0 queue empty", q0.size(), 0);
    chk("dut1 queue empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_gap_gen.md
Name: pipe_gap_gen

Overview:
- Parametrised successor to the 9-bit pipe-height LFSR.
- Galois LFSR of configurable width, tap mask and seed, plus:
  - req/valid handshake;
  - range mapping of the random value into [MIN_Y, MAX_Y];
  - optional clamp on the change from the previous gap, for playability;
  - runtime seed load and entropy "stir" input.
- Feeds the pipe spawner. One request yields one pipe gap y-coordinate.

Parameters:
- WIDTH, 9, LFSR and output width.
- TAPS, 9'h070, Galois feedback mask, XORed into the rotated state when the MSB is 1.
- SEED, 9'd205, reset value and fallback for zero seeds.
- MIN_Y, 80, lowest legal gap y.
- MAX_Y, 335, highest legal gap y. Requires MAX_Y ≥ MIN_Y and MAX_Y < 2^WIDTH.
- MAX_DELTA, 0, maximum |gap − previous gap|. 0 disables the clamp.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request a new gap, single-cycle pulse
- ready  out  1  high in IDLE; req is accepted only when ready=1
- gap_y  out  WIDTH  registered gap y, holds its value between results
- gap_valid  out  1  one-cycle pulse when gap_y updates
- stir  in  1  advance the LFSR one step while idle
- seed_load  in  1  load seed_val into the LFSR
- seed_val  in  WIDTH  seed value

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous, active-low (rst_n).
  - Reset values: lfsr=SEED, state=IDLE, gap_y=(MIN_Y+MAX_Y)/2, prev=(MIN_Y+MAX_Y)/2, gap_valid=0, ready=1.
- LFSR step: next = {lfsr[WIDTH-2:0], lfsr[WIDTH-1]} ^ (lfsr[WIDTH-1] ? TAPS : 0).
- Derived constant: span = MAX_Y − MIN_Y + 1.
- IDLE state:
  - If req: lfsr←next, r←next, go to REDUCE.
  - Else if stir: lfsr←next, stay in IDLE.
- REDUCE state:
  - If r ≥ span: r←r−span, stay in REDUCE.
  - Else: go to CLAMP.
  - k = number of subtractions, with k ≤ ceil(2^WIDTH/span).
- CLAMP state:
  - raw = MIN_Y + r.
  - If MAX_DELTA≠0 and raw > prev+MAX_DELTA: use prev+MAX_DELTA.
  - If MAX_DELTA≠0 and raw + MAX_DELTA < prev: use prev−MAX_DELTA.
  - Do the comparisons at WIDTH+1 bits with no wrap. The clamped value is always within [MIN_Y, MAX_Y] because prev is.
  - gap_y←result, prev←result, gap_valid←1 for one cycle, then return to IDLE.
- Latency: gap_valid is high in the cycle 2+k clock edges after the edge that samples req. Minimum is 2, when k=0.
- ready = (state==IDLE). req while ready=0 is ignored and not queued.
- seed_load has the highest priority, in any state:
  - lfsr←(seed_val==0 ? SEED : seed_val).
  - state←IDLE; any in-flight request is aborted with no gap_valid.
  - gap_y and prev are unchanged.
  - req or stir in the same cycle is ignored.
- req and stir in the same IDLE cycle: the LFSR advances once only, for the req.
- Lock-up guard: if lfsr==0 in any cycle, it is reloaded with SEED on the next edge. This has priority under seed_load.
- Reset mid-operation: immediate return to the reset values; no gap_valid.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum {IDLE, REDUCE, CLAMP};
  - the default TAPS/SEED constants for widths 8, 9 and 10;
  - MIN_Y/MAX_Y screen constants shared with the renderer.
- One natural sub-module: lfsr_galois (WIDTH, TAPS, SEED).
  - Inputs: clk, rst_n, step, load, load_val.
  - Output: q.
  - Reusable elsewhere for particle effects.

Test Plan:
- Reset, default params, MAX_DELTA=0; req pulse → gap_y=234 (lfsr 410, k=1), gap_valid 3 edges after req; second req → lfsr 325, gap_y=149 (k=1).
- Same as above with MAX_DELTA=40 → first gap_y=234 (|234−207|=27, no clamp); second raw 149 clamped to 194.
- req held high continuously → ready deasserts after acceptance; exactly one gap_valid per IDLE acceptance; no requests queued; LFSR advances once per accepted req.
- stir for 1 cycle from reset, then req → sampled value is the 2nd LFSR step from 205 (325) → gap_y=149.
- seed_load with seed_val=0 during REDUCE → lfsr=205, state IDLE, no gap_valid, gap_y unchanged; seed_load with seed_val=9'h1FF then req → lfsr=9'h18F (399), gap_y=223.
- Assert rst_n low asynchronously mid-REDUCE → outputs return to reset values without waiting for a clock edge; 511 consecutive stir steps from SEED return to 205 (maximal-length check) and never hit 0.
